// File: rtl/weight_stream_mem.sv
// weight_stream_mem: banked word storage with a random-access write port and a
// burst read engine that streams LANES consecutive words per beat to the MAC
// array over a valid/ready handshake, with accept/completion pulses.
module weight_stream_mem #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int LANES  = 4,
   parameter int LEN_W  = ADDR_W - $clog2(LANES) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    trig_w,
   input  logic [ADDR_W-1:0]       abus_w,
   input  logic [DATA_W-1:0]       dbus_w,
   input  logic                    req,
   input  logic [ADDR_W-1:0]       base,
   input  logic [LEN_W-1:0]        len,
   output logic                    ack,
   output logic                    busy,
   output logic [DATA_W*LANES-1:0] dbus_r,
   output logic                    valid,
   input  logic                    ready,
   output logic                    last,
   output logic                    done
);

   localparam int LANE_B = $clog2(LANES);
   localparam int ROWS   = (1 << ADDR_W) / LANES;
   // Keep the row index at least one bit wide even when a single row remains.
   localparam int ROW_W  = (ADDR_W > LANE_B) ? ADDR_W - LANE_B : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic [ROW_W-1:0]        row_p0;
   logic [ROW_W-1:0]        row_inc;
   logic [ROW_W-1:0]        base_row;
   logic [ROW_W-1:0]        wr_row;
   logic [ADDR_W-1:0]       wr_bank;
   logic [LEN_W-1:0]        remain;
   logic [DATA_W*LANES-1:0] rd_p0;
   logic                    accept;
   logic                    issue;
   logic                    fin;

   // Word address a lives in bank a mod LANES at row a / LANES.
   assign wr_bank  = abus_w & ADDR_W'(LANES - 1);
   assign wr_row   = ROW_W'(abus_w >> LANE_B);
   assign base_row = ROW_W'(base >> LANE_B);
   assign row_inc  = (row_p0 == ROW_W'(ROWS - 1)) ? '0 : row_p0 + ROW_W'(1);

   for (genvar b = 0; b < LANES; b++) begin : g_bank
      logic [DATA_W-1:0] mem [ROWS];

      // Bank write: only the bank owning abus_w stores the word; never reset.
      always_ff @(posedge clk) begin
         if (trig_w && (wr_bank == ADDR_W'(b))) begin
            mem[wr_row] <= dbus_w;
         end
      end

      // Read-first: a same-edge write lands after this value is registered.
      assign rd_p0[b*DATA_W +: DATA_W] = mem[row_p0];
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus the accept / issue / finish strobes.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      issue     = 1'b0;
      fin       = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               accept    = 1'b1;
               state_nxt = (len == '0) ? FLUSH : RUN;
            end
         end
         RUN: begin
            if (!valid || ready) begin
               issue = 1'b1;
               if (remain == LEN_W'(1)) begin
                  state_nxt = FLUSH;
               end
            end
         end
         FLUSH: begin
            // With beats the last one is still held in the output register;
            // with len=0 valid is already low, so this finishes at once.
            if (!valid || ready) begin
               fin       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Burst bookkeeping: row pointer, beats remaining, ack/busy/done pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         row_p0 <= '0;
         remain <= '0;
      end else begin
         ack  <= accept;
         done <= fin;
         if (accept) begin
            busy <= 1'b1;
         end else if (fin) begin
            busy <= 1'b0;
         end
         if (accept) begin
            row_p0 <= base_row;
            remain <= len;
         end else if (issue) begin
            row_p0 <= row_inc;
            remain <= remain - LEN_W'(1);
         end
      end
   end

   // ---- stage p0 (bank read) -> p1 (output register) ----
   // Output beat register: loads on issue, holds under backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dbus_r <= '0;
         valid  <= 1'b0;
         last   <= 1'b0;
      end else if (issue) begin
         dbus_r <= rd_p0;
         valid  <= 1'b1;
         last   <= (remain == LEN_W'(1));
      end else if (valid && ready) begin
         valid  <= 1'b0;
         last   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_weight_stream_mem.sv
// tb_weight_stream_mem: randomized and directed bursts against a word-array
// reference model of the memory and the burst/handshake rules.
module tb_weight_stream_mem;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int LANES  = 4;
   localparam int LEN_W  = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trig_w = 1'b0;
   logic [7:0]  abus_w = '0;
   logic [7:0]  dbus_w = '0;
   logic        req = 1'b0;
   logic [7:0]  base = '0;
   logic [6:0]  len = '0;
   logic        ready = 1'b1;
   logic        ack, busy, valid, last, done;
   logic [31:0] dbus_r;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem_m [256];
   logic [31:0] got_beats [$];
   logic        got_last [$];
   int          ack_cnt, done_cnt, done_cyc, first_vld_cyc, cons_cyc;
   int          stall_err, valid_cnt;
   logic        ack_at1, busy_at1, busy_at_done;
   bit          timeout;

   always #5 clk = ~clk;

   weight_stream_mem #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst), .trig_w(trig_w), .abus_w(abus_w), .dbus_w(dbus_w),
      .req(req), .base(base), .len(len), .ack(ack), .busy(busy),
      .dbus_r(dbus_r), .valid(valid), .ready(ready), .last(last), .done(done)
   );

   // Beat k of a burst from base b: LANES words from the aligned row, wrapping.
   function automatic logic [31:0] exp_beat(input logic [7:0] b, input int k);
      int row;
      logic [31:0] r;
      row = (int'(b) / 4 + k) % 64;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = mem_m[row*4 + i];
      return r;
   endfunction

   task automatic write_word(input logic [7:0] a, input logic [7:0] d);
      abus_w = a; dbus_w = d; trig_w = 1'b1;
      @(posedge clk); #1;
      trig_w = 1'b0;
      mem_m[a] = d;
   endtask

   // Runs one burst, recording beats and handshake timing (cycle 1 = after req edge).
   task automatic do_burst(input logic [7:0] b, input logic [6:0] l, input int rmode,
                           input int req_at, input int wr_at,
                           input logic [7:0] wa, input logic [7:0] wd);
      int cyc;
      logic stalled;
      logic [31:0] held;
      got_beats.delete(); got_last.delete();
      ack_cnt = 0; done_cnt = 0; done_cyc = -1; first_vld_cyc = -1; cons_cyc = -1;
      stall_err = 0; valid_cnt = 0; timeout = 0; ack_at1 = 0; busy_at1 = 0; busy_at_done = 1;
      stalled = 0; held = '0; cyc = 0;
      base = b; len = l; req = 1'b1; ready = 1'b1;
      while (1) begin
         @(posedge clk); #1; cyc++;
         req = (cyc == req_at);
         if (req) begin base = 8'($urandom); len = 7'd3; end
         trig_w = (cyc == wr_at); abus_w = wa; dbus_w = wd;
         if (cyc == 1) begin ack_at1 = ack; busy_at1 = busy; end
         ack_cnt += int'(ack);
         if (valid) begin valid_cnt++; if (first_vld_cyc < 0) first_vld_cyc = cyc; end
         if (stalled && (!valid || dbus_r !== held)) stall_err++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
         end
         if (done_cyc >= 0 && cyc > done_cyc) break;
         if (cyc > 200) begin timeout = 1; break; end
         case (rmode)
            0: ready = 1'b1;
            1: ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         if (valid && ready) begin
            got_beats.push_back(dbus_r); got_last.push_back(last); cons_cyc = cyc;
         end
         stalled = valid && !ready;
         held = dbus_r;
      end
      req = 1'b0; trig_w = 1'b0; ready = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #2;
      checks++; if ({ack, busy, valid, last, done} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {ack, busy, valid, last, done}); end
      checks++; if (dbus_r !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", dbus_r); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int a = 0; a < 256; a++) write_word(8'(a), 8'($urandom));
   endtask

   task automatic test_basic();
      for (int a = 0; a < 16; a++) write_word(8'(a), 8'(a + 16));
      do_burst(8'h00, 7'd4, 0, 0, 0, 8'h0, 8'h0);
      checks++; if (ack_at1 !== 1'b1 || ack_cnt !== 1) begin errors++; $display("FAIL basic_ack: got first=%b count=%0d expected first=1 count=1", ack_at1, ack_cnt); end
      checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_at1); end
      checks++; if (got_beats.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", got_beats.size()); end
      for (int k = 0; k < got_beats.size() && k < 4; k++) begin
         checks++; if (got_beats[k] !== 32'h13121110 + 32'h04040404 * k) begin errors++; $display("FAIL basic_beat%0d: got %h expected %h", k, got_beats[k], 32'h13121110 + 32'h04040404 * k); end
         checks++; if (got_last[k] !== (k == 3)) begin errors++; $display("FAIL basic_last%0d: got %b expected %b", k, got_last[k], (k == 3)); end
      end
      checks++; if (first_vld_cyc !== 2 || cons_cyc !== 5) begin errors++; $display("FAIL basic_timing: got first=%0d lastcons=%0d expected 2 5", first_vld_cyc, cons_cyc); end
      checks++; if (done_cyc !== 6 || done_cnt !== 1) begin errors++; $display("FAIL basic_done: got cyc=%0d count=%0d expected 6 1", done_cyc, done_cnt); end
      checks++; if (busy_at_done !== 1'b0 || timeout) begin errors++; $display("FAIL basic_busy_done: got busy=%b timeout=%0d expected 0 0", busy_at_done, timeout); end
   endtask

   task automatic test_backpressure();
      do_burst(8'h00, 7'd4, 1, 0, 0, 8'h0, 8'h0);
      checks++; if (got_beats.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", got_beats.size()); end
      for (int k = 0; k < got_beats.size() && k < 4; k++) begin
         checks++; if (got_beats[k] !== exp_beat(8'h00, k) || got_last[k] !== (k == 3)) begin errors++; $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", k, got_beats[k], got_last[k], exp_beat(8'h00, k), (k == 3)); end
      end
      checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stall_err); end
      checks++; if (done_cnt !== 1 || done_cyc !== cons_cyc + 1) begin errors++; $display("FAIL bp_done: got count=%0d cyc=%0d expected 1 %0d", done_cnt, done_cyc, cons_cyc + 1); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 8; i++) write_word(8'(8'hFC + i), 8'(8'hC0 + i));
      do_burst(8'hFC, 7'd2, 0, 0, 0, 8'h0, 8'h0);
      checks++; if (got_beats.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", got_beats.size()); end
      else begin
         checks++; if (got_beats[0] !== 32'hC3C2C1C0) begin errors++; $display("FAIL wrap_beat0: got %h expected c3c2c1c0", got_beats[0]); end
         checks++; if (got_beats[1] !== 32'hC7C6C5C4 || got_last[1] !== 1'b1) begin errors++; $display("FAIL wrap_beat1: got %h/%b expected c7c6c5c4/1", got_beats[1], got_last[1]); end
      end
   endtask

   task automatic test_collision();
      logic [31:0] e1;
      e1 = exp_beat(8'h00, 1);
      do_burst(8'h00, 7'd2, 0, 0, 2, 8'h04, 8'hAA);
      mem_m[4] = 8'hAA;
      checks++; if (got_beats.size() !== 2 || got_beats[1] !== e1) begin errors++; $display("FAIL coll_old: got %h expected %h", (got_beats.size() > 1) ? got_beats[1] : 32'hx, e1); end
      do_burst(8'h00, 7'd2, 0, 0, 0, 8'h0, 8'h0);
      checks++; if (got_beats.size() !== 2 || got_beats[1] !== exp_beat(8'h00, 1) || got_beats[1][7:0] !== 8'hAA) begin errors++; $display("FAIL coll_new: got %h expected %h", (got_beats.size() > 1) ? got_beats[1] : 32'hx, exp_beat(8'h00, 1)); end
   endtask

   task automatic test_len_zero();
      do_burst(8'h10, 7'd0, 0, 0, 0, 8'h0, 8'h0);
      checks++; if (ack_at1 !== 1'b1 || ack_cnt !== 1 || busy_at1 !== 1'b1) begin errors++; $display("FAIL len0_ack: got ack=%b cnt=%0d busy=%b expected 1 1 1", ack_at1, ack_cnt, busy_at1); end
      checks++; if (done_cyc !== 2 || done_cnt !== 1 || busy_at_done !== 1'b0) begin errors++; $display("FAIL len0_done: got cyc=%0d cnt=%0d busy=%b expected 2 1 0", done_cyc, done_cnt, busy_at_done); end
      checks++; if (valid_cnt !== 0 || got_beats.size() !== 0) begin errors++; $display("FAIL len0_valid: got %0d valid cycles expected 0", valid_cnt); end
   endtask

   task automatic test_req_during_run();
      do_burst(8'h20, 7'd6, 0, 3, 0, 8'h0, 8'h0);
      checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL run_req_ack: got %0d acks expected 1", ack_cnt); end
      checks++; if (got_beats.size() !== 6) begin errors++; $display("FAIL run_req_count: got %0d expected 6", got_beats.size()); end
      for (int k = 0; k < got_beats.size() && k < 6; k++) begin
         checks++; if (got_beats[k] !== exp_beat(8'h20, k)) begin errors++; $display("FAIL run_req_beat%0d: got %h expected %h", k, got_beats[k], exp_beat(8'h20, k)); end
      end
   endtask

   task automatic test_back_to_back();
      base = 8'h00; len = 7'd1; req = 1'b1; ready = 1'b1;
      @(posedge clk); #1; req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", done); end
      base = 8'h30; len = 7'd1; req = 1'b1;
      @(posedge clk); #1; req = 1'b0;
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack: got %b expected 1", ack); end
      @(posedge clk); #1;
      checks++; if (valid !== 1'b1 || dbus_r !== exp_beat(8'h30, 0) || last !== 1'b1) begin errors++; $display("FAIL b2b_beat: got %b %h %b expected 1 %h 1", valid, dbus_r, last, exp_beat(8'h30, 0)); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_burst();
      base = 8'h08; len = 7'd8; req = 1'b1; ready = 1'b0;
      @(posedge clk); #1; req = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got valid=%b busy=%b expected 1 1", valid, busy); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({ack, busy, valid, last, done} !== 5'b0 || dbus_r !== 32'h0) begin errors++; $display("FAIL rstmid_async: got %b %h expected 00000 00000000", {ack, busy, valid, last, done}, dbus_r); end
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_nodone: got done=%b busy=%b expected 0 0", done, busy); end
      rst = 1'b1; ready = 1'b1;
      do_burst(8'h08, 7'd3, 0, 0, 0, 8'h0, 8'h0);
      checks++; if (got_beats.size() !== 3 || done_cnt !== 1) begin errors++; $display("FAIL rstmid_after: got %0d beats %0d done expected 3 1", got_beats.size(), done_cnt); end
      for (int k = 0; k < got_beats.size() && k < 3; k++) begin
         checks++; if (got_beats[k] !== exp_beat(8'h08, k)) begin errors++; $display("FAIL rstmid_beat%0d: got %h expected %h", k, got_beats[k], exp_beat(8'h08, k)); end
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic [6:0] l;
      for (int it = 0; it < 25; it++) begin
         repeat ($urandom_range(0, 4)) write_word(8'($urandom), 8'($urandom));
         b = 8'($urandom);
         l = ($urandom_range(0, 6) == 0) ? 7'd0 : 7'($urandom_range(1, 9));
         do_burst(b, l, 2, 0, 0, 8'h0, 8'h0);
         checks++; if (got_beats.size() !== int'(l) || done_cnt !== 1 || timeout) begin errors++; $display("FAIL rand%0d_count: got %0d beats %0d done expected %0d 1", it, got_beats.size(), done_cnt, l); end
         checks++; if (stall_err !== 0) begin errors++; $display("FAIL rand%0d_stable: got %0d expected 0", it, stall_err); end
         for (int k = 0; k < got_beats.size() && k < int'(l); k++) begin
            checks++; if (got_beats[k] !== exp_beat(b, k) || got_last[k] !== (k == int'(l) - 1)) begin errors++; $display("FAIL rand%0d_beat%0d: got %h/%b expected %h/%b", it, k, got_beats[k], got_last[k], exp_beat(b, k), (k == int'(l) - 1)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_collision();
      test_len_zero();
      test_req_during_run();
      test_back_to_back();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
